// File: rtl/fifo_pkg.sv
// Shared gray/binary pointer helpers for the dual-clock FIFO write and read sides.
package fifo_pkg;

   // Widest pointer the helpers handle; callers zero-extend in and truncate out.
   localparam int unsigned PTR_MAX_W = 32;

   // Binary to reflected gray code.
   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary by prefix XOR from the MSB down; zero-extension leaves the result intact.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/write_full_ctrl.sv
// Write-side pointer and flag controller for the dual-clock gray-pointer FIFO.
module write_full_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_addr_size     = 2,
   parameter int unsigned ALMOST_FULL_THRESH = 3
) (
   input  logic                      clk_w,
   input  logic                      rst_w,
   input  logic                      w_en,
   input  logic [FIFO_addr_size:0]   r_pointer_gray_sync,
   input  logic                      clr_overflow,
   output logic [FIFO_addr_size-1:0] w_addr,
   output logic [FIFO_addr_size:0]   w_pointer_gray,
   output logic                      full,
   output logic                      almost_full,
   output logic [FIFO_addr_size:0]   w_level,
   output logic                      overflow
);

   localparam int unsigned A  = FIFO_addr_size;
   localparam int unsigned PW = A + 1;

   // The two pointer MSBs that differ between a full write pointer and the read pointer.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (A - 1);

   logic [PW-1:0] w_pointer_bin_q, w_pointer_bin_d;
   logic [PW-1:0] w_pointer_gray_q, w_pointer_gray_d;
   logic [PW-1:0] w_level_q, w_level_d;
   logic          full_q, full_d;
   logic          almost_full_q, almost_full_d;
   logic          overflow_q, overflow_d;

   logic          accept;
   logic [PW-1:0] r_bin;

   // Next-state pointers, occupancy against the synced read pointer, and the sticky overflow.
   always_comb begin
      accept           = w_en & ~full_q;
      w_pointer_bin_d  = w_pointer_bin_q + PW'(accept);
      w_pointer_gray_d = PW'(bin2gray(PTR_MAX_W'(w_pointer_bin_d)));
      r_bin            = PW'(gray2bin(PTR_MAX_W'(r_pointer_gray_sync)));
      full_d           = (w_pointer_gray_d == (r_pointer_gray_sync ^ FULL_MASK));
      w_level_d        = w_pointer_bin_d - r_bin;
      almost_full_d    = (32'(w_level_d) >= ALMOST_FULL_THRESH);
      overflow_d       = overflow_q;
      if (w_en & full_q) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // All state registers; reset overrides every other input.
   always_ff @(posedge clk_w) begin
      if (rst_w) begin
         w_pointer_bin_q  <= '0;
         w_pointer_gray_q <= '0;
         w_level_q        <= '0;
         full_q           <= 1'b0;
         almost_full_q    <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         w_pointer_bin_q  <= w_pointer_bin_d;
         w_pointer_gray_q <= w_pointer_gray_d;
         w_level_q        <= w_level_d;
         full_q           <= full_d;
         almost_full_q    <= almost_full_d;
         overflow_q       <= overflow_d;
      end
   end

   assign w_addr         = w_pointer_bin_q[A-1:0];
   assign w_pointer_gray = w_pointer_gray_q;
   assign full           = full_q;
   assign almost_full    = almost_full_q;
   assign w_level        = w_level_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_write_full_ctrl.sv
// Directed bench for write_full_ctrl with A=2 (DEPTH=4), almost-full threshold 3.
module tb_write_full_ctrl;

   logic       clk_w = 1'b0;
   logic       rst_w;
   logic       w_en;
   logic [2:0] r_pointer_gray_sync;
   logic       clr_overflow;
   logic [1:0] w_addr;
   logic [2:0] w_pointer_gray;
   logic       full;
   logic       almost_full;
   logic [2:0] w_level;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   write_full_ctrl #(.FIFO_addr_size(2), .ALMOST_FULL_THRESH(3)) dut (
      .clk_w               (clk_w),
      .rst_w               (rst_w),
      .w_en                (w_en),
      .r_pointer_gray_sync (r_pointer_gray_sync),
      .clr_overflow        (clr_overflow),
      .w_addr              (w_addr),
      .w_pointer_gray      (w_pointer_gray),
      .full                (full),
      .almost_full         (almost_full),
      .w_level             (w_level),
      .overflow            (overflow)
   );

   always #5 clk_w = ~clk_w;

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge clk_w);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output snapshot: gray, addr, level, full, almost_full, overflow.
   task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] a,
                          input logic [2:0] lvl, input logic f, input logic af, input logic ov);
      chk({tag, ".gray"}, 32'(w_pointer_gray), 32'(g));
      chk({tag, ".addr"}, 32'(w_addr), 32'(a));
      chk({tag, ".level"}, 32'(w_level), 32'(lvl));
      chk({tag, ".full"}, 32'(full), 32'(f));
      chk({tag, ".afull"}, 32'(almost_full), 32'(af));
      chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
   endtask

   function automatic logic [2:0] to_gray(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [2:0] wb;
      logic [2:0] prev_gray;

      rst_w = 1'b1; w_en = 1'b0; r_pointer_gray_sync = 3'b000; clr_overflow = 1'b0;
      step();
      step();
      chk_all("reset", 3'b000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_w = 1'b0;

      // Fill from empty.
      w_en = 1'b1;
      step(); chk_all("fill1", 3'b001, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0);
      step(); chk_all("fill2", 3'b011, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0);
      step(); chk_all("fill3", 3'b010, 2'd3, 3'd3, 1'b0, 1'b1, 1'b0);
      step(); chk_all("fill4", 3'b110, 2'd0, 3'd4, 1'b1, 1'b1, 1'b0);

      // Writes while full are dropped and set overflow.
      step(); chk_all("ovf1", 3'b110, 2'd0, 3'd4, 1'b1, 1'b1, 1'b1);
      step(); chk_all("ovf2", 3'b110, 2'd0, 3'd4, 1'b1, 1'b1, 1'b1);
      w_en = 1'b0;
      step(); chk("ovf_hold", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      step(); chk("ovf_clr", 32'(overflow), 32'd0);
      w_en = 1'b1;
      step(); chk("ovf_set_wins", 32'(overflow), 32'd1);
      chk("ovf_set_wins.gray", 32'(w_pointer_gray), 32'(3'b110));
      w_en = 1'b0; clr_overflow = 1'b0;

      // Read pointer advances release full.
      r_pointer_gray_sync = 3'b001;
      step(); chk_all("rd1", 3'b110, 2'd0, 3'd3, 1'b0, 1'b1, 1'b1);
      r_pointer_gray_sync = 3'b011;
      step(); chk_all("rd2", 3'b110, 2'd0, 3'd2, 1'b0, 1'b0, 1'b1);

      // Continuous write with read trailing by two, wrapping the pointers.
      wb = 3'd4;
      prev_gray = w_pointer_gray;
      w_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         r_pointer_gray_sync = to_gray(wb - 3'd1);
         wb = wb + 3'd1;
         step();
         chk("wrap.gray", 32'(w_pointer_gray), 32'(to_gray(wb)));
         chk("wrap.onebit", 32'($countones(w_pointer_gray ^ prev_gray)), 32'd1);
         chk("wrap.level", 32'(w_level), 32'd2);
         chk("wrap.full", 32'(full), 32'd0);
         prev_gray = w_pointer_gray;
      end
      // wb=0, read bin=6.

      // Reach level 3, then write and read together.
      step(); chk_all("lvl3", 3'b001, 2'd1, 3'd3, 1'b0, 1'b1, 1'b1);
      r_pointer_gray_sync = to_gray(3'd7);
      step(); chk_all("wr_rd", 3'b011, 2'd2, 3'd3, 1'b0, 1'b1, 1'b1);

      // Fill, overflow, then reset while full.
      clr_overflow = 1'b1;
      step(); chk_all("full2", 3'b010, 2'd3, 3'd4, 1'b1, 1'b1, 1'b0);
      clr_overflow = 1'b0;
      step(); chk_all("full2_ovf", 3'b010, 2'd3, 3'd4, 1'b1, 1'b1, 1'b1);
      rst_w = 1'b1; r_pointer_gray_sync = 3'b000;
      step(); chk_all("rst_full", 3'b000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_w = 1'b0;
      step(); chk_all("post_rst", 3'b001, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0);
      w_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
